// File: rtl/shift_pkg.sv
// Shared types and constants for the operand-2 shift sequencer.
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by k (0..16) bits and reports
// the last bit shifted out; k = 0 passes data and carry through untouched.
module shift_step
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic              carry_in,
    input  logic [1:0]        sh,
    input  logic [4:0]        k,
    output logic [DATA_W-1:0] data_out,
    output logic              carry_out
);

    logic [4:0]        inv_k_s;
    logic [DATA_W-1:0] rot_s;

    // Complementary distance used for the LSL carry tap and the ROR wrap-around.
    always_comb begin
        inv_k_s = 5'(6'd32 - {1'b0, k});
        rot_s   = (data_in >> k) | (data_in << inv_k_s);
    end

    // Shift by k according to the shift type.
    always_comb begin
        data_out  = data_in;
        carry_out = carry_in;
        if (k == 5'd0) begin
            data_out  = data_in;
            carry_out = carry_in;
        end else begin
            case (sh)
                SH_LSL: begin
                    data_out  = data_in << k;
                    carry_out = data_in[inv_k_s];
                end
                SH_LSR: begin
                    data_out  = data_in >> k;
                    carry_out = data_in[k - 5'd1];
                end
                SH_ASR: begin
                    data_out  = $signed(data_in) >>> k;
                    carry_out = data_in[k - 5'd1];
                end
                SH_ROR: begin
                    data_out  = rot_s;
                    carry_out = rot_s[DATA_W-1];
                end
                default: begin
                    data_out  = data_in;
                    carry_out = carry_in;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle ARM operand-2 shifter: decodes the shift request, resolves the
// zero-iteration encodings directly and iterates up to STEP bits per cycle.
module shift_seq
    import shift_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        inst,
    input  logic              enable,
    input  logic [7:0]        rs_val,
    input  logic [DATA_W-1:0] operand,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    state_t            state_r;
    state_t            state_next_s;
    logic [DATA_W-1:0] work_r;
    logic              carry_r;
    logic [CNT_W-1:0]  remaining_r;
    logic [1:0]        sh_r;
    logic              out_valid_r;

    logic              accept_s;
    logic [1:0]        sh_in_s;
    logic              imm_zero_s;
    logic [7:0]        n_s;
    logic [7:0]        n_eff_s;
    logic              zero_iter_s;
    logic [DATA_W-1:0] direct_data_s;
    logic              direct_carry_s;
    logic [CNT_W-1:0]  cnt_s;
    logic [4:0]        k_s;
    logic [DATA_W-1:0] step_data_s;
    logic              step_carry_s;

    assign in_ready  = (state_r == IDLE) && !reset;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign result    = work_r;
    assign carry_out = carry_r;

    // Request decode: amount selection, special encodings and iteration count.
    always_comb begin
        sh_in_s        = inst[2:1];
        imm_zero_s     = !inst[0] && (inst[7:3] == 5'd0);
        n_s            = inst[0] ? rs_val : {3'b000, inst[7:3]};
        n_eff_s        = imm_zero_s ? 8'd32 : n_s;
        zero_iter_s    = 1'b1;
        direct_data_s  = operand;
        direct_carry_s = carry_in;
        cnt_s          = {CNT_W{1'b0}};
        if (!enable) begin
            zero_iter_s = 1'b1;
        end else if (inst[0] && (rs_val == 8'd0)) begin
            zero_iter_s = 1'b1;
        end else if (imm_zero_s && (sh_in_s == SH_LSL)) begin
            zero_iter_s = 1'b1;
        end else if (imm_zero_s && (sh_in_s == SH_ROR)) begin
            // RRX: one-bit rotate through the carry flag
            direct_data_s  = {carry_in, operand[DATA_W-1:1]};
            direct_carry_s = operand[0];
        end else if ((sh_in_s == SH_ROR) && (n_s[4:0] == 5'd0)) begin
            direct_carry_s = operand[DATA_W-1];
        end else begin
            zero_iter_s = 1'b0;
            case (sh_in_s)
                SH_LSL, SH_LSR: cnt_s = (n_eff_s > 8'd33) ? 6'd33 : n_eff_s[CNT_W-1:0];
                SH_ASR:         cnt_s = (n_eff_s > 8'd32) ? 6'd32 : n_eff_s[CNT_W-1:0];
                SH_ROR:         cnt_s = {1'b0, n_s[4:0]};
                default:        cnt_s = {CNT_W{1'b0}};
            endcase
        end
    end

    // Per-cycle shift distance: whatever is left, capped at STEP.
    always_comb begin
        if (remaining_r > STEP_C) begin
            k_s = STEP_C[4:0];
        end else begin
            k_s = remaining_r[4:0];
        end
    end

    shift_step u_step (
        .data_in   (work_r),
        .carry_in  (carry_r),
        .sh        (sh_r),
        .k         (k_s),
        .data_out  (step_data_s),
        .carry_out (step_carry_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = zero_iter_s ? DONE : SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (remaining_r == {1'b0, k_s}) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Working register, carry, remaining count and the registered valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_r      <= {DATA_W{1'b0}};
            carry_r     <= 1'b0;
            remaining_r <= {CNT_W{1'b0}};
            sh_r        <= SH_LSL;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sh_r <= sh_in_s;
                        if (zero_iter_s) begin
                            work_r      <= direct_data_s;
                            carry_r     <= direct_carry_s;
                            remaining_r <= {CNT_W{1'b0}};
                        end else begin
                            work_r      <= operand;
                            carry_r     <= carry_in;
                            remaining_r <= cnt_s;
                        end
                    end
                end
                SHIFT: begin
                    work_r      <= step_data_s;
                    carry_r     <= step_carry_s;
                    remaining_r <= remaining_r - {1'b0, k_s};
                end
                default: begin
                    work_r <= work_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Directed, table-driven bench for shift_seq with STEP = 8.
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  inst;
    logic        enable;
    logic [7:0]  rs_val;
    logic [31:0] operand;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  inst;
        logic        en;
        logic [7:0]  rs;
        logic [31:0] op;
        logic        ci;
        logic [31:0] res;
        logic        co;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    shift_seq #(.STEP(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .enable    (enable),
        .rs_val    (rs_val),
        .operand   (operand),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, scramble inputs after accept, measure latency, stall, release.
    task automatic send(input vec_t v, input int hold, input int idx);
        int lat;
        chk($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
        inst = v.inst; enable = v.en; rs_val = v.rs; operand = v.op; carry_in = v.ci;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        inst = ~v.inst; enable = ~v.en; rs_val = ~v.rs; operand = ~v.op; carry_in = ~v.ci;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d result", idx), result, v.res);
        chk($sformatf("v%0d carry", idx), {31'd0, carry_out}, {31'd0, v.co});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk($sformatf("v%0d stall valid", idx), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d stall result", idx), result, v.res);
            chk($sformatf("v%0d stall carry", idx), {31'd0, carry_out}, {31'd0, v.co});
            chk($sformatf("v%0d stall in_ready", idx), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d valid drop", idx), {31'd0, out_valid}, 32'd0);
        chk($sformatf("v%0d ready back", idx), {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        //          inst    en    rs     operand        ci    result         co    lat
        vecs[0]  = '{8'h20, 1'b1, 8'd0,   32'h8000_000F, 1'b0, 32'h0000_00F0, 1'b0, 1};
        vecs[1]  = '{8'h03, 1'b1, 8'd33,  32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 5};
        vecs[2]  = '{8'h03, 1'b1, 8'd32,  32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 4};
        vecs[3]  = '{8'h04, 1'b1, 8'd0,   32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 4};
        vecs[4]  = '{8'h06, 1'b1, 8'd0,   32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1, 0};
        vecs[5]  = '{8'h07, 1'b1, 8'd36,  32'h0000_0012, 1'b0, 32'h2000_0001, 1'b0, 1};
        vecs[6]  = '{8'h07, 1'b1, 8'd64,  32'h8000_1234, 1'b0, 32'h8000_1234, 1'b1, 0};
        vecs[7]  = '{8'h03, 1'b1, 8'd0,   32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 0};
        vecs[8]  = '{8'hFF, 1'b0, 8'd77,  32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 0};
        vecs[9]  = '{8'h01, 1'b1, 8'd32,  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 4};
        vecs[10] = '{8'h01, 1'b1, 8'd40,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 5};
        vecs[11] = '{8'h05, 1'b1, 8'd200, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 4};
        vecs[12] = '{8'h02, 1'b1, 8'd0,   32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 4};
        vecs[13] = '{8'h46, 1'b1, 8'd0,   32'h0000_00A5, 1'b0, 32'hA500_0000, 1'b1, 1};
        vecs[14] = '{8'h0C, 1'b1, 8'd0,   32'h8000_0002, 1'b1, 32'hC000_0001, 1'b0, 1};
        vecs[15] = '{8'h8A, 1'b1, 8'd0,   32'h0003_0000, 1'b0, 32'h0000_0001, 1'b1, 3};
        vecs[16] = '{8'hF8, 1'b1, 8'd0,   32'h0000_0003, 1'b0, 32'h8000_0000, 1'b1, 4};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        inst = 8'h00; enable = 1'b0; rs_val = 8'h00; operand = 32'h0; carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst result", result, 32'h0);
        chk("rst carry", {31'd0, carry_out}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            send(vecs[i], 0, i);
        end

        // Pass-through held in DONE with out_ready low for five cycles.
        send(vecs[8], 5, 100);

        // Reset in the middle of a 33-bit LSR.
        inst = 8'h03; enable = 1'b1; rs_val = 8'd33; operand = 32'hFFFF_FFFF; carry_in = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid-shift in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid rst result", result, 32'h0);
        chk("mid rst carry", {31'd0, carry_out}, 32'd0);
        chk("mid rst in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("after rst out_valid", {31'd0, out_valid}, 32'd0);
        send(vecs[1], 0, 200);

        // Reset while DONE is stalled.
        inst = 8'h06; enable = 1'b1; operand = 32'h0000_0003; carry_in = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("done stall valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("done rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("done rst result", result, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        send(vecs[0], 0, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle sequencer for the operand-2 shifter of the ARM datapath. It accepts one shift request: instruction bits 11:4, the shift-enable bit (instruction bit 25 semantics), the Rm operand, the low byte of Rs and the current C flag. It shifts iteratively by at most STEP bits per cycle and returns the ALU source-2 value plus the shifter carry-out. It applies full ARM semantics: amounts ≥ 32, the #0 encodings and RRX. It sits between the register-file read stage and the ALU, with valid/ready handshakes on both sides.

## Interface
- STEP, 8, maximum shift distance per cycle; power of two, 1..16.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept (= state IDLE and not reset).
- inst  in  8  instruction bits 11:4.
  - inst[0]: 1 = register amount, 0 = immediate.
  - inst[2:1]: sh. 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - inst[7:3]: shamt5.
- enable  in  1  1 = shift; 0 = pass operand through unchanged.
- rs_val  in  8  Rs[7:0], used when inst[0]=1.
- operand  in  32  Rm value.
- carry_in  in  1  current C flag.
- out_valid  out  1  result/carry_out valid.
- out_ready  in  1  consumer takes result.
- result  out  32  shifted operand.
- carry_out  out  1  shifter carry-out.

## Operation
- States: IDLE, SHIFT, DONE. Inputs are captured on accept (in_valid & in_ready); later input changes are ignored.
- Amount n: immediate → shamt5; register → rs_val (0..255).
- Zero-iteration cases go IDLE→DONE with result/carry set directly:
  - enable=0: operand, carry_in.
  - Register n=0 (any sh): operand, carry_in.
  - Immediate LSL #0: operand, carry_in.
  - Immediate ROR #0 = RRX: {carry_in, operand[31:1]}, operand[0].
  - ROR, n≠0, n mod 32 = 0: operand, operand[31].
- Iterative count cnt:
  - Immediate LSR #0 and ASR #0 mean n=32.
  - LSL/LSR: cnt = min(n,33).
  - ASR: cnt = min(n,32).
  - ROR: cnt = n mod 32.
- SHIFT: each cycle shift the working register by k = min(remaining, STEP) and set carry to the last bit shifted out.
  - LSL/LSR fill with zeros; ASR fills with the sign bit; ROR rotates.
  - remaining -= k. When remaining reaches 0 → DONE.
- Resulting semantics:
  - LSL 32: 0, C = op[0].
  - LSR 32: 0, C = op[31].
  - LSL/LSR > 32: 0, C = 0.
  - ASR ≥ 32: all op[31], C = op[31].
  - ROR: C = result[31].
- DONE: out_valid=1, result and carry_out held stable. out_ready → IDLE. One request in flight; no accept during SHIFT or DONE.
- Width rules: remaining is 6 bits (max 33); k ≤ STEP; shift arithmetic in 32 bits, plus a 1-bit carry register.

## Timing
- Reset (synchronous, any state, including mid-SHIFT or DONE with out_ready low):
  - state IDLE, out_valid 0, result 0, carry_out 0, remaining 0.
  - In-flight request discarded. in_ready 0 during reset cycles, 1 from the first cycle after.
- Request accepted at edge t:
  - Zero-iteration case: out_valid=1 in cycle t+1.
  - Otherwise: out_valid=1 in cycle t+1+ceil(cnt/STEP). STEP=8, LSR #32 → 4 SHIFT cycles; LSR by 33 → 5.
- out_valid & out_ready at edge u → IDLE. in_ready=1 in cycle u+1, and a new accept is possible at edge u+1. Throughput is 1 request per (latency + 1) cycles minimum.
- out_ready without out_valid is ignored. in_valid outside IDLE is ignored; the requester holds it.

## Structure
- Package shift_pkg:
  - sh encodings SH_LSL/SH_LSR/SH_ASR/SH_ROR.
  - State enum {IDLE, SHIFT, DONE}.
  - Constants DATA_W=32, CNT_W=6.
- Sub-module shift_step: combinational single-step shifter (data, carry, sh, k ≤ STEP → data, carry). Instantiated once.
- Top holds the FSM, count clamping, special-case decode and output registers.

## Test plan
- Imm LSL #4 (inst=8'h20), operand 32'h8000_000F, enable=1, STEP=8 → 1 SHIFT cycle; result 32'h0000_00F0, carry_out 0, out_valid at t+2.
- Reg LSR, rs_val=33, operand 32'hFFFF_FFFF → 5 SHIFT cycles; result 0, carry_out 0. Same with rs_val=32 → 4 cycles; result 0, carry_out 1.
- Imm ASR #0 (inst=8'h04), operand 32'h8000_0000 → result 32'hFFFF_FFFF, carry_out 1. Imm ROR #0 (inst=8'h06), carry_in=1, operand 32'h0000_0003 → result 32'h8000_0001, carry_out 1, out_valid at t+1.
- Reg ROR, rs_val=36, operand 32'h0000_0012 → result 32'h2000_0001, carry_out 0. rs_val=64 → operand unchanged, carry_out=operand[31]. Reg n=0 with carry_in=1 → operand, carry_out 1.
- enable=0 with any inst → result=operand, carry_out=carry_in, out_valid at t+1. out_ready held low 5 cycles → outputs stable, in_ready 0.
- Assert reset during SHIFT of a 33-bit LSR → next cycle out_valid 0, result 0, carry_out 0. First accept after reset completes normally.
